// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SHL/SHR/SAR/ROL/ROR) with a valid/ready handshake on both sides.
// Define SH_FLAGS_EN to add the registered out_zero / out_carry flag outputs.
module shift_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [$clog2(WIDTH):0] in_n,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef SH_FLAGS_EN
    ,
    output logic                   out_zero,
    output logic                   out_carry
`endif
);

    localparam int LG        = $clog2(WIDTH);
    localparam int NW        = LG + 1;
    localparam int LEVELS    = LG + 1;
    localparam int PER_STAGE = (LEVELS + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef logic [WIDTH-1:0] word_t;

    // Level lvl shifts by 2**lvl; the top level (lvl == LG) is the full-width step,
    // which clears SHL/SHR, sign-fills SAR and is an identity for rotates.
    function automatic word_t level_data(input logic [2:0] op, input word_t v, input int lvl);
        word_t r;
        int    amt;
        amt = 1 << lvl;
        r   = v;
        case (op)
            OP_SHL:  r = v << amt;
            OP_SHR:  r = v >> amt;
            OP_SAR:  r = word_t'($signed(v) >>> amt);
            OP_ROL:  r = (v << amt) | (v >> (WIDTH - amt));
            OP_ROR:  r = (v >> amt) | (v << (WIDTH - amt));
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef SH_FLAGS_EN
    function automatic logic level_carry(input logic [2:0] op, input word_t v, input int lvl,
                                         input logic c_in);
        logic c;
        int   amt;
        amt = 1 << lvl;
        c   = c_in;
        case (op)
            OP_SHL:         c = |(v & (word_t'(1) << (WIDTH - amt)));
            OP_SHR, OP_SAR: c = |(v & (word_t'(1) << (amt - 1)));
            default:        c = c_in;
        endcase
        return c;
    endfunction
`endif

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic            valid_d, valid_q;
        logic [2:0]      op_d;
        logic [NW-1:0]   n_d;
        word_t           data_in, data_d, data_q;
`ifdef SH_FLAGS_EN
        logic            carry_in, carry_d, carry_q;
`endif

        if (s == 0) begin : g_src
            assign valid_d = in_valid;
            assign op_d    = in_op;
            assign n_d     = in_n;
            assign data_in = in_data;
`ifdef SH_FLAGS_EN
            assign carry_in = 1'b0;
`endif
        end else begin : g_src
            assign valid_d = g_stage[s-1].valid_q;
            assign op_d    = g_stage[s-1].g_fwd.op_q;
            assign n_d     = g_stage[s-1].g_fwd.n_q;
            assign data_in = g_stage[s-1].data_q;
`ifdef SH_FLAGS_EN
            assign carry_in = g_stage[s-1].carry_q;
`endif
        end

        always_comb begin
            data_d = data_in;
`ifdef SH_FLAGS_EN
            carry_d = carry_in;
`endif
            for (int l = s * PER_STAGE; l < (s + 1) * PER_STAGE; l++) begin
                if (l < LEVELS && (n_d & (NW'(1) << l)) != '0) begin
`ifdef SH_FLAGS_EN
                    carry_d = level_carry(op_d, data_d, l, carry_d);
`endif
                    data_d = level_data(op_d, data_d, l);
                end
            end
`ifdef SH_FLAGS_EN
            // Rotate carry is the bit that wrapped last, i.e. the end bit of the final result.
            if (s == STAGES - 1 && n_d != '0) begin
                if (op_d == OP_ROL) begin
                    carry_d = data_d[0];
                end else if (op_d == OP_ROR) begin
                    carry_d = data_d[WIDTH-1];
                end
            end
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
`ifdef SH_FLAGS_EN
                carry_q <= 1'b0;
`endif
            end else if (advance) begin
                valid_q <= valid_d;
                data_q  <= data_d;
`ifdef SH_FLAGS_EN
                carry_q <= carry_d;
`endif
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [2:0]    op_q;
            logic [NW-1:0] n_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_q <= '0;
                    n_q  <= '0;
                end else if (advance) begin
                    op_q <= op_d;
                    n_q  <= n_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign out_data  = g_stage[STAGES-1].data_q;

`ifdef SH_FLAGS_EN
    logic zero_d, zero_q;

    assign zero_d = (g_stage[STAGES-1].data_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= zero_d;
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = g_stage[STAGES-1].carry_q;
`endif

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe (WIDTH=32, STAGES=2); flag checks follow SH_FLAGS_EN.
module tb_shift_unit_pipe;

    localparam logic [2:0] SHL = 3'd0;
    localparam logic [2:0] SHR = 3'd1;
    localparam logic [2:0] SAR = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [5:0]  in_n = 6'd0;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
`ifdef SH_FLAGS_EN
    logic        out_zero;
    logic        out_carry;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    int          cycle = 0;
    bit          mon_en = 1'b0;
    logic [33:0] sb[$];
    int          pop_cyc[$];

    shift_unit_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_n      (in_n),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SH_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // {zero, carry, data}
    function automatic logic [33:0] exp_of(input logic [31:0] d, input logic c);
        return {d == 32'h0, c, d};
    endfunction

    function automatic logic [33:0] model(input logic [2:0] op, input logic [5:0] n,
                                          input logic [31:0] d);
        logic [31:0] r;
        logic        c;
        logic [63:0] dd;
        int          k, m;
        k  = int'(n);
        m  = k % 32;
        r  = d;
        c  = 1'b0;
        dd = {d, d};
        case (op)
            SHL: begin
                r = (k >= 32) ? 32'h0 : d << k;
                c = (k >= 1 && k <= 32) ? |(d & (32'h1 << (32 - k))) : 1'b0;
            end
            SHR: begin
                r = (k >= 32) ? 32'h0 : d >> k;
                c = (k >= 1 && k <= 32) ? |(d & (32'h1 << (k - 1))) : 1'b0;
            end
            SAR: begin
                r = (k >= 32) ? {32{d[31]}} : 32'($signed(d) >>> k);
                c = (k == 0) ? 1'b0 : (k <= 32) ? |(d & (32'h1 << (k - 1))) : d[31];
            end
            ROL: begin
                dd = dd << m;
                r  = dd[63:32];
                c  = (k != 0) ? r[0] : 1'b0;
            end
            ROR: begin
                dd = dd >> m;
                r  = dd[31:0];
                c  = (k != 0) ? r[31] : 1'b0;
            end
            default: begin
                r = d;
                c = 1'b0;
            end
        endcase
        return {r == 32'h0, c, r};
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        logic        ok;
        if (mon_en && !rst && out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output: got out_data=%h, required no output", out_data);
            end else begin
                e = sb.pop_front();
                pop_cyc.push_back(cycle);
                ok = (out_data === e[31:0]);
`ifdef SH_FLAGS_EN
                ok = ok && (out_zero === e[33]) && (out_carry === e[32]);
                if (!ok)
                    $display("FAIL result: got data=%h zero=%b carry=%b, required data=%h zero=%b carry=%b",
                             out_data, out_zero, out_carry, e[31:0], e[33], e[32]);
`else
                if (!ok)
                    $display("FAIL result: got data=%h, required data=%h (flags %b)",
                             out_data, e[31:0], e[33:32]);
`endif
                if (ok) n_pass++;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [5:0] n, input logic [31:0] d,
                        input logic [33:0] exp);
        bit acc;
        int guard;
        acc      = 1'b0;
        guard    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_n     = n;
        in_data  = d;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (acc) begin
            sb.push_back(exp);
        end else begin
            n_total++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h, required 0", out_data);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else n_pass++;
`ifdef SH_FLAGS_EN
        n_total++;
        if ({out_zero, out_carry} !== 2'b00)
            $display("FAIL reset_flags: got %b%b, required 00", out_zero, out_carry);
        else n_pass++;
`endif
        in_valid = 1'b1;
        in_op    = SHL;
        in_n     = 6'd1;
        in_data  = 32'h5;
        @(posedge clk);
        #1;
        in_data = 32'h7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flight_rst_out_valid: got %b, required 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== 32'h0) $display("FAIL flight_rst_out_data: got %h, required 0", out_data);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL flight_rst_in_ready: got %b, required 1", in_ready);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL stale_after_rst: got out_valid=%b, required 0", out_valid);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_shl();
        send(SHL, 6'd31, 32'h00000001, exp_of(32'h80000000, 1'b0));
        idle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: got out_valid=%b, required 0", out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h80000000)
            $display("FAIL latency_two: got valid=%b data=%h, required 1 80000000", out_valid, out_data);
        else n_pass++;
        send(SHL, 6'd32, 32'h00000001, exp_of(32'h0, 1'b1));
        send(SHL, 6'd40, 32'h00000001, exp_of(32'h0, 1'b0));
        idle();
        drain("shl");
    endtask

    task automatic test_shr_sar();
        send(SHR, 6'd4,  32'h80000000, exp_of(32'h08000000, 1'b0));
        send(SAR, 6'd4,  32'h80000000, exp_of(32'hF8000000, 1'b0));
        send(SAR, 6'd33, 32'h80000000, exp_of(32'hFFFFFFFF, 1'b1));
        idle();
        drain("shr_sar");
    endtask

    task automatic test_rotate();
        send(ROR, 6'd8,  32'h12345678, exp_of(32'h78123456, 1'b0));
        send(ROR, 6'd32, 32'h12345678, exp_of(32'h12345678, 1'b0));
        send(ROL, 6'd36, 32'h12345678, exp_of(32'h23456781, 1'b1));
        idle();
        drain("rotate");
    endtask

    task automatic test_flags();
        send(SHL,  6'd1,  32'h80000001, exp_of(32'h00000002, 1'b1));
        send(SHR,  6'd1,  32'h00000001, exp_of(32'h00000000, 1'b1));
        send(SHL,  6'd0,  32'hA5A5A5A5, exp_of(32'hA5A5A5A5, 1'b0));
        send(3'd6, 6'd9,  32'h0F0F0F0F, exp_of(32'h0F0F0F0F, 1'b0));
        send(SAR,  6'd32, 32'h7FFFFFFF, exp_of(32'h00000000, 1'b0));
        send(ROL,  6'd1,  32'h80000000, exp_of(32'h00000001, 1'b1));
        idle();
        drain("flags");
    endtask

    task automatic test_back_to_back();
        pop_cyc.delete();
        out_ready = 1'b1;
        fork
            begin
                send(SHL, 6'd4, 32'h00000001, exp_of(32'h00000010, 1'b0));
                send(SHR, 6'd1, 32'h00000008, exp_of(32'h00000004, 1'b0));
                send(ROL, 6'd4, 32'hF0000000, exp_of(32'h0000000F, 1'b1));
                send(ROR, 6'd4, 32'h0000000F, exp_of(32'hF0000000, 1'b1));
                idle();
            end
            begin
                int g;
                g = 0;
                while (!out_valid && g < 20) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                if (!out_valid) begin
                    n_total++;
                    $display("FAIL b2b_first_valid: got out_valid=%b, required 1", out_valid);
                end else begin
                    out_ready = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        n_total++;
                        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00000010)
                            $display("FAIL b2b_stall: got ready=%b valid=%b data=%h, required 0 1 00000010",
                                     in_ready, out_valid, out_data);
                        else n_pass++;
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1'b1;
                end
            end
        join
        drain("b2b");
        n_total++;
        if (pop_cyc.size() != 4) begin
            $display("FAIL b2b_count: got %0d results, required 4", pop_cyc.size());
        end else if (pop_cyc[1] - pop_cyc[0] != 1 || pop_cyc[2] - pop_cyc[1] != 1 ||
                     pop_cyc[3] - pop_cyc[2] != 1) begin
            $display("FAIL b2b_spacing: got cycles %0d %0d %0d %0d, required consecutive",
                     pop_cyc[0], pop_cyc[1], pop_cyc[2], pop_cyc[3]);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_random();
        fork
            begin
                logic [2:0]  op;
                logic [5:0]  n;
                logic [31:0] d;
                for (int i = 0; i < 40; i++) begin
                    op = 3'($urandom_range(0, 7));
                    n  = 6'($urandom_range(0, 63));
                    d  = $urandom;
                    send(op, n, d, model(op, n, d));
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
            end
            begin
                for (int j = 0; j < 80; j++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("random");
    endtask

    initial begin
        test_reset();
        test_shl();
        test_shr_sar();
        test_rotate();
        test_flags();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
